mul_add: RTL and testbench
==========================

MUL_ADD -- requirements
Module: mul_add

Interface
REQ-001 Parameters: none; all widths are fixed constants taken from the shared package.
REQ-002 CLOCK  input  1  single clock; all state updates on the rising edge.
REQ-003 RESET_B  input  1  synchronous, active-low reset, sampled on the rising CLOCK edge.
REQ-004 START  input  1  request to begin an operation, sampled on the rising edge.
REQ-005 MQ  input  8  multiplier (quotient side), unsigned.
REQ-006 MD  input  4  multiplicand (divisor side), unsigned.
REQ-007 AD  input  4  addend (remainder side), unsigned.
REQ-008 PROD  output  12  result MQ*MD+AD, unsigned.
REQ-009 BUSY  output  1  high while an operation is in progress.
REQ-010 DONE  output  1  one-cycle pulse marking PROD valid.

Function
REQ-011 The block SHALL compute PROD = MQ*MD + AD exactly; the maximum is 255*15+15 = 3840, so the result never overflows 12 bits.
REQ-012 The block SHALL implement the states IDLE, RUN and FIN.
REQ-013 In IDLE or FIN, START=1 at an edge SHALL capture MQ/MD/AD, load the accumulator with zero-extended AD, clear the 3-bit step counter and enter RUN.
REQ-014 MQ/MD/AD SHALL be ignored at every edge other than the accepting edge.
REQ-015 RUN SHALL last exactly 8 edges. At step i (0..7), if captured MQ bit i is 1, add MD<<i to the accumulator; otherwise hold.
REQ-016 After step 7 the state SHALL be FIN, PROD SHALL equal the final accumulator, and DONE SHALL be 1 for exactly that one cycle.
REQ-017 Latency: with START accepted at edge k, DONE SHALL be high in the cycle following edge k+8.
REQ-018 BUSY SHALL be 1 exactly while the state is RUN.
REQ-019 FIN SHALL return to IDLE at the next edge unless START=1, in which case a new operation is accepted (back-to-back, 9-cycle throughput).
REQ-020 START while in RUN SHALL be ignored, with no effect on the captured operands or the count.
REQ-021 PROD SHALL hold its last result from FIN until the next accepted START; intermediate accumulator values need not appear on PROD.
REQ-022 MQ=0 or MD=0 SHALL yield PROD=AD, with the same 9-cycle latency.

Reset
REQ-023 RESET_B=0 at an edge SHALL force state IDLE, PROD=0, BUSY=0, DONE=0, counter=0 and accumulator=0, regardless of START.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no DONE pulse; the first START after reset release SHALL produce a correct result.

Structure
REQ-025 A shared package SHALL hold the width constants (MQ 8, MD 4, AD 4, PROD 12), the step count (8) and the state encoding (IDLE/RUN/FIN).
REQ-026 The add step SHALL be a single sub-module, mul_add_step: a 12-bit conditional add of MD<<i into the accumulator, combinational.
REQ-027 The FSM, step counter and operand/accumulator registers SHALL reside in mul_add.

Verification
REQ-028 MQ=200, MD=7, AD=4, START pulse at edge k -> PROD=1404 with DONE=1 in the cycle after edge k+8; BUSY high for 8 cycles.
REQ-029 MQ=255, MD=15, AD=15 -> PROD=3840; MQ=0, MD=9, AD=5 -> PROD=5; MQ=17, MD=0, AD=3 -> PROD=3.
REQ-030 START pulsed again at RUN cycle 3 with different operands -> ignored, and the first result is delivered unchanged; START held during the FIN cycle -> DONE pulses once, then BUSY=1 at the next edge and the second result follows 9 cycles later.
REQ-031 RESET_B=0 for one edge at RUN step 4 -> outputs 0 and state IDLE, with no DONE; then MQ=12, MD=12, AD=0 -> PROD=144.
REQ-032 Round trip: for each (DD, DQ) with DQ≠0, exhaustive over 8-bit DD and 4-bit DQ, feed the divider results (quotient, divisor, remainder) as MQ, MD, AD -> PROD SHALL equal DD in every case.

Source files
------------

// File: rtl/mul_add_pkg.sv
// Shared widths, step count and FSM encoding for the shift-add multiply-add unit.
package mul_add_pkg;

  localparam int MQ_W   = 8;
  localparam int MD_W   = 4;
  localparam int AD_W   = 4;
  localparam int PROD_W = 12;
  localparam int STEPS  = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/mul_add_step.sv
// One shift-add step: conditionally adds MD shifted by the step index into the accumulator.
module mul_add_step
  import mul_add_pkg::*;
(
  input  logic [PROD_W-1:0] acc_i,
  input  logic [MD_W-1:0]   md_i,
  input  logic              bit_i,
  input  logic [CNT_W-1:0]  sh_i,
  output logic [PROD_W-1:0] sum_o
);

  logic [PROD_W-1:0] md_sh;

  // Partial product for this bit; the result cannot exceed 12 bits for 8x4 operands.
  always_comb begin
    md_sh = {{(PROD_W-MD_W){1'b0}}, md_i} << sh_i;
    sum_o = bit_i ? (acc_i + md_sh) : acc_i;
  end

endmodule

// File: rtl/mul_add.sv
// Sequential PROD = MQ*MD + AD: one multiplier bit per cycle over 8 RUN cycles.
module mul_add
  import mul_add_pkg::*;
(
  input  logic              CLOCK,
  input  logic              RESET_B,
  input  logic              START,
  input  logic [MQ_W-1:0]   MQ,
  input  logic [MD_W-1:0]   MD,
  input  logic [AD_W-1:0]   AD,
  output logic [PROD_W-1:0] PROD,
  output logic              BUSY,
  output logic              DONE
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MQ_W-1:0]   mq_q, mq_d;
  logic [MD_W-1:0]   md_q, md_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] prod_q, prod_d;
  logic [PROD_W-1:0] acc_step;
  logic              accept;
  logic              last_step;

  mul_add_step u_step (
    .acc_i (acc_q),
    .md_i  (md_q),
    .bit_i (mq_q[cnt_q]),
    .sh_i  (cnt_q),
    .sum_o (acc_step)
  );

  // START is only honoured outside RUN, so operands are frozen for the whole operation.
  assign accept    = START && (state_q != ST_RUN);
  assign last_step = (state_q == ST_RUN) && (cnt_q == CNT_W'(STEPS-1));

  // Next-state logic: IDLE/FIN accept START, RUN leaves after the eighth step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (START) state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_FIN;
      ST_FIN:  state_d = START ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state: capture on accept, step while running, publish on the last step.
  always_comb begin
    cnt_d  = cnt_q;
    mq_d   = mq_q;
    md_d   = md_q;
    acc_d  = acc_q;
    prod_d = prod_q;
    if (accept) begin
      mq_d  = MQ;
      md_d  = MD;
      acc_d = {{(PROD_W-AD_W){1'b0}}, AD};
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      acc_d = acc_step;
      cnt_d = cnt_q + 1'b1;
      if (last_step) prod_d = acc_step;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!RESET_B) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mq_q    <= '0;
      md_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mq_q    <= mq_d;
      md_q    <= md_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign PROD = prod_q;
  assign BUSY = (state_q == ST_RUN);
  assign DONE = (state_q == ST_FIN);

endmodule

// File: tb/tb_mul_add.sv
// Directed bench for mul_add: hand-computed vectors plus a divide/multiply round trip.
module tb_mul_add;

  logic        clk;
  logic        rst_b;
  logic        start;
  logic [7:0]  mq;
  logic [3:0]  md;
  logic [3:0]  ad;
  logic [11:0] prod;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  mul_add dut (
    .CLOCK   (clk),
    .RESET_B (rst_b),
    .START   (start),
    .MQ      (mq),
    .MD      (md),
    .AD      (ad),
    .PROD    (prod),
    .BUSY    (busy),
    .DONE    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scramble();
    mq = 8'($urandom);
    md = 4'($urandom);
    ad = 4'($urandom);
  endtask

  // Wait for DONE with a bound; lat = edges after accept (-1 on timeout), bsy = BUSY cycles seen.
  task automatic wait_done(output int lat, output int bsy);
    lat = -1;
    bsy = busy ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done) begin
        lat = i + 1;
        break;
      end
      if (busy) bsy++;
    end
  endtask

  // Accept one operation; returns at the FIN cycle (or after timeout).
  task automatic do_op(input string tag, input int a, input int b, input int c,
                       input int exp, input bit full);
    int lat, bsy;
    mq = 8'(a); md = 4'(b); ad = 4'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    wait_done(lat, bsy);
    chk({tag, "_prod"}, int'(prod), exp);
    if (full) begin
      chk({tag, "_lat"}, lat, 9);
      chk({tag, "_busy"}, bsy, 8);
      chk({tag, "_busy_fin"}, int'(busy), 0);
    end
  endtask

  initial begin
    int lat, bsy, q, r;
    rst_b = 1'b0;
    start = 1'b1;
    mq = 8'd200; md = 4'd7; ad = 4'd4;
    tick();
    tick();
    chk("rst_prod", int'(prod), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    start = 1'b0;
    rst_b = 1'b1;
    tick();
    chk("idle_busy", int'(busy), 0);

    // Main vectors.
    do_op("v200x7p4", 200, 7, 4, 1404, 1);
    tick();
    chk("fin_to_idle_done", int'(done), 0);
    chk("hold_prod", int'(prod), 1404);
    do_op("vmax", 255, 15, 15, 3840, 1);
    do_op("vmq0", 0, 9, 5, 5, 1);
    do_op("vmd0", 17, 0, 3, 3, 1);
    do_op("v1x1p0", 1, 1, 0, 1, 0);
    do_op("v128x8p1", 128, 8, 1, 1025, 0);

    // START during RUN cycle 3 with other operands must be ignored.
    tick();
    mq = 8'd200; md = 4'd7; ad = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    tick(); tick();
    mq = 8'd3; md = 4'd3; ad = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("midrun_busy", int'(busy), 1);
    lat = -1;
    for (int i = 4; i <= 20; i++) begin
      tick();
      if (done) begin lat = i + 1; break; end
    end
    chk("midrun_lat", lat, 9);
    chk("midrun_prod", int'(prod), 1404);

    // START held in FIN: back-to-back accept, next DONE 9 cycles later.
    mq = 8'd12; md = 4'd5; ad = 4'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_done_once", int'(done), 0);
    chk("b2b_prod_hold", int'(prod), 1404);
    wait_done(lat, bsy);
    chk("b2b_lat", lat, 9);
    chk("b2b_prod", int'(prod), 67);

    // Reset at RUN step 4 aborts with no DONE.
    tick();
    mq = 8'd200; md = 4'd7; ad = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    chk("abort_prod", int'(prod), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    bsy = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) bsy++;
    end
    chk("abort_quiet", bsy, 0);
    do_op("post_rst", 12, 12, 0, 144, 1);

    // Round trip: quotient*divisor + remainder reproduces the dividend.
    for (int dd = 0; dd < 256; dd++) begin
      for (int dq = 1; dq < 16; dq++) begin
        q = dd / dq;
        r = dd % dq;
        do_op($sformatf("rt_%0d_%0d", dd, dq), q, dq, r, dd, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
